collision_detector: RTL and testbench
=====================================

# collision_detector

Pixel-rate collision stage directly downstream of the rock manager's per-rock `pixel` bus and upstream of its `reset` bus. It accumulates rock/bullet and rock/ship overlaps over one video frame. At each frame end it issues one-cycle rock retire pulses, a bullet retire pulse and a ship-hit pulse, then updates a 4-digit BCD score and a lives counter for the display and game-control logic.

## Interface
- `NUM_ROCKS`, 10, rock slots; width of `rock_pixel` and `rock_reset`.
- `START_LIVES`, 3, lives loaded at reset (1..3).
- `INVULN_FRAMES`, 120, frames of ship invulnerability after a ship hit (2 s at 60 Hz).
- `clk`  in  1  pixel clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `frame_end`  in  1  one-cycle strobe after the last visible pixel of each frame.
- `rock_pixel`  in  NUM_ROCKS  bit i high while rock i covers the current pixel.
- `ship_pixel`  in  1  ship covers the current pixel.
- `bullet_pixel`  in  1  bullet covers the current pixel.
- `rock_reset`  out  NUM_ROCKS  one-cycle retire pulses to the rock manager `reset` bus.
- `bullet_hit`  out  1  one-cycle pulse; bullet hit at least one rock this frame.
- `ship_hit`  out  1  one-cycle pulse; a non-invulnerable ship was hit this frame.
- `score`  out  16  4-digit BCD score; ones digit is always 0.
- `lives`  out  2  remaining lives.
- `game_over`  out  1  sticky; lives reached 0.

## Operation
- Live sticky flags, per rock i: `bhit[i]` sets on `rock_pixel[i] & bullet_pixel`, and `shit[i]` sets on `rock_pixel[i] & ship_pixel`. Flags set in every state.
- FSM states: SCAN, COMMIT, SCORE.
- SCAN: accumulate. When `frame_end` is high, go to COMMIT.
- COMMIT, one cycle:
  - `rock_reset = bhit | shit`.
  - `bullet_hit = |bhit`.
  - `ship_hit = |shit & ~invuln & ~game_over`.
  - Snapshot `bhit` into a score shift register, then clear both live flag sets. An overlap on that same cycle sets the flag in the new frame.
  - Go to SCORE.
- SCORE: exactly NUM_ROCKS cycles. Each cycle, shift out one snapshot bit; if it is 1 and `game_over` = 0, add 10 to the score. Then go to SCAN.
- A `frame_end` in COMMIT or SCORE is ignored. Flags keep accumulating until the next accepted `frame_end`.
- Score arithmetic: BCD +10 increments the tens digit with decimal carry. The score saturates at 9990 and never wraps.
- Lives: decrement on the `ship_hit` cycle. On transition to 0, set `game_over` on the same cycle.
- A ship hit loads the invulnerability counter with INVULN_FRAMES. `invuln = (counter != 0)`. The counter decrements once per accepted `frame_end`, so the hit frame itself is not counted.
- In game_over:
  - `rock_reset` and `bullet_hit` are still issued.
  - `score`, `lives` and the invulnerability counter are frozen.
  - `ship_hit` is held at 0.

## Timing
- Reset values:
  - `rock_reset` = 0, `bullet_hit` = 0, `ship_hit` = 0.
  - `score` = 0x0000, `lives` = START_LIVES, `game_over` = 0.
  - FSM = SCAN, all flags and counters = 0.
- Let `frame_end` be high at cycle T (state SCAN).
  - Pulses are high only at T+1.
  - Score additions take effect at the end of cycles T+2 … T+1+NUM_ROCKS. The final score is visible at T+2+NUM_ROCKS.
  - The FSM is back in SCAN at T+2+NUM_ROCKS.
- Pulses are registered outputs and are never high for two consecutive cycles.
- Asserting `resetn` mid-SCORE abandons the pending additions. `score` is 0 immediately, asynchronously.
- Simultaneous bullet and ship hit on the same rock: the rock is retired once, scored once, and the ship is hit.

## Structure
- Shared package `rocks_pkg`:
  - `NUM_ROCKS` default.
  - FSM state enum (SCAN/COMMIT/SCORE).
  - `bcd_digit_t` (4-bit).
  - `SCORE_MAX` (16'h9990).
- Sub-module `bcd_score_counter`:
  - Inputs: `clk`, `resetn`, `inc10`, `hold`.
  - Output: 16-bit BCD score with saturation.
  - Owns all decimal-carry logic.

## Test plan
- Bullet overlaps rock 3 for one pixel, then `frame_end` at T -> `rock_reset` = 10'h008 and `bullet_hit` = 1 at T+1 only; `score` = 0x0010 at T+12.
- Bullet overlaps rocks 0, 5, 9 in one frame; score preset at 0x0990 -> `rock_reset` = 10'h221; score = 0x1020 at T+12.
- Ship overlaps rock 1 -> `ship_hit` = 1 at T+1; `lives` 3→2. A ship overlap in the next frame gives `rock_reset` = 10'h002, `ship_hit` = 0, lives stays 2. After 121 further frames, a hit decrements lives again.
- Three spaced ship hits -> `lives` = 0 and `game_over` = 1 on the third `ship_hit` cycle. A later bullet hit still retires the rock with no score change.
- Score 0x9990 plus a bullet hit -> score stays 0x9990. A second `frame_end` at T+5 is ignored and flags carry to the next frame. `resetn` low at T+4 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rocks_pkg.sv
// Shared definitions for the rock field: slot count, collision FSM states and
// BCD score types.
package rocks_pkg;

  localparam int NUM_ROCKS = 10;

  typedef enum logic [1:0] {
    SCAN,
    COMMIT,
    SCORE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] SCORE_MAX = 16'h9990;

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score counting in steps of ten. The ones digit is
// permanently zero and the count saturates at SCORE_MAX.
module bcd_score_counter
  import rocks_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inc10,
  input  logic        hold,
  output logic [15:0] score
);

  bcd_digit_t tens;
  bcd_digit_t hundreds;
  bcd_digit_t thousands;

  assign score = {thousands, hundreds, tens, 4'h0};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tens      <= '0;
      hundreds  <= '0;
      thousands <= '0;
    end else if (inc10 && !hold && (score != SCORE_MAX)) begin
      if (tens == 4'd9) begin
        tens <= '0;
        if (hundreds == 4'd9) begin
          hundreds  <= '0;
          thousands <= thousands + 4'd1;
        end else begin
          hundreds <= hundreds + 4'd1;
        end
      end else begin
        tens <= tens + 4'd1;
      end
    end
  end

endmodule

// File: rtl/collision_detector.sv
// Per-frame rock/bullet and rock/ship collision accumulation, retire pulses,
// score, lives and ship invulnerability.
module collision_detector #(
  parameter int NUM_ROCKS     = rocks_pkg::NUM_ROCKS,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 frame_end,
  input  logic [NUM_ROCKS-1:0] rock_pixel,
  input  logic                 ship_pixel,
  input  logic                 bullet_pixel,
  output logic [NUM_ROCKS-1:0] rock_reset,
  output logic                 bullet_hit,
  output logic                 ship_hit,
  output logic [15:0]          score,
  output logic [1:0]           lives,
  output logic                 game_over
);

  import rocks_pkg::*;

  localparam int CW = $clog2(NUM_ROCKS + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 2);

  state_t                 state;
  state_t                 state_next;
  logic [NUM_ROCKS-1:0]   bhit;
  logic [NUM_ROCKS-1:0]   shit;
  logic [NUM_ROCKS-1:0]   bhit_new;
  logic [NUM_ROCKS-1:0]   shit_new;
  logic [NUM_ROCKS-1:0]   snap;
  logic [CW-1:0]          score_cnt;
  logic [IW-1:0]          invuln_cnt;
  logic                   accept;
  logic                   invuln;
  logic                   hit_now;
  logic                   inc10;

  assign bhit_new = rock_pixel & {NUM_ROCKS{bullet_pixel}};
  assign shit_new = rock_pixel & {NUM_ROCKS{ship_pixel}};
  assign accept   = (state == SCAN) && frame_end;
  assign invuln   = (invuln_cnt != '0);
  // Registered pulses fire on the cycle after the accepted frame_end, so they
  // include any overlap seen on the frame_end cycle itself.
  assign hit_now  = accept && |(shit | shit_new) && !invuln && !game_over;
  assign inc10    = (state == SCORE) && snap[0] && !game_over;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      SCAN:    if (frame_end) state_next = COMMIT;
      COMMIT:  state_next = SCORE;
      SCORE:   if (score_cnt == CW'(NUM_ROCKS - 1)) state_next = SCAN;
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= SCAN;
      bhit      <= '0;
      shit      <= '0;
      snap      <= '0;
      score_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == COMMIT) begin
        snap      <= bhit;
        bhit      <= bhit_new;
        shit      <= shit_new;
        score_cnt <= '0;
      end else begin
        bhit <= bhit | bhit_new;
        shit <= shit | shit_new;
        if (state == SCORE) begin
          snap      <= snap >> 1;
          score_cnt <= score_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rock_reset <= '0;
      bullet_hit <= 1'b0;
      ship_hit   <= 1'b0;
      lives      <= 2'(START_LIVES);
      game_over  <= 1'b0;
      invuln_cnt <= '0;
    end else begin
      rock_reset <= accept ? (bhit | bhit_new | shit | shit_new) : '0;
      bullet_hit <= accept && |(bhit | bhit_new);
      ship_hit   <= hit_now;
      if (hit_now) begin
        lives <= lives - 2'd1;
        if (lives == 2'd1) game_over <= 1'b1;
      end
      // The hit frame loads the counter; later accepted frames count it down.
      if (accept && !game_over) begin
        if (hit_now)     invuln_cnt <= IW'(INVULN_FRAMES);
        else if (invuln) invuln_cnt <= invuln_cnt - IW'(1);
      end
    end
  end

  bcd_score_counter u_score (
    .clk    (clk),
    .resetn (resetn),
    .inc10  (inc10),
    .hold   (game_over),
    .score  (score)
  );

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: expectations are queued as stimulus
// is driven and popped when the outputs are sampled on the falling edge.
module tb_collision_detector;

  localparam int NR = 10;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          frame_end = 1'b0;
  logic [NR-1:0] rock_pixel = '0;
  logic          ship_pixel = 1'b0;
  logic          bullet_pixel = 1'b0;
  logic [NR-1:0] rock_reset;
  logic          bullet_hit;
  logic          ship_hit;
  logic [15:0]   score;
  logic [1:0]    lives;
  logic          game_over;

  always #5 clk = ~clk;

  collision_detector #(
    .NUM_ROCKS     (NR),
    .START_LIVES   (3),
    .INVULN_FRAMES (120)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_end    (frame_end),
    .rock_pixel   (rock_pixel),
    .ship_pixel   (ship_pixel),
    .bullet_pixel (bullet_pixel),
    .rock_reset   (rock_reset),
    .bullet_hit   (bullet_hit),
    .ship_hit     (ship_hit),
    .score        (score),
    .lives        (lives),
    .game_over    (game_over)
  );

  typedef enum {S_RR, S_BH, S_SH, S_SC, S_LV, S_GO} sig_e;
  typedef struct {
    sig_e        sig;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   hits  = 0;

  function automatic logic [15:0] observe(sig_e s);
    case (s)
      S_RR:    return {6'd0, rock_reset};
      S_BH:    return {15'd0, bullet_hit};
      S_SH:    return {15'd0, ship_hit};
      S_SC:    return score;
      S_LV:    return {14'd0, lives};
      default: return {15'd0, game_over};
    endcase
  endfunction

  // Decimal model of the score: ten points per hit, capped at 999 hits.
  function automatic logic [15:0] to_bcd(int n);
    int m;
    m = (n > 999) ? 999 : n;
    return {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10), 4'h0};
  endfunction

  task automatic push_exp(sig_e s, logic [15:0] v, string tag);
    exp_t e;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      tests++;
      assert (obs === e.val)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic push_reset_values(string tag);
    push_exp(S_RR, 16'h0000, {tag, "_rock_reset"});
    push_exp(S_BH, 16'h0000, {tag, "_bullet_hit"});
    push_exp(S_SH, 16'h0000, {tag, "_ship_hit"});
    push_exp(S_SC, 16'h0000, {tag, "_score"});
    push_exp(S_LV, 16'h0003, {tag, "_lives"});
    push_exp(S_GO, 16'h0000, {tag, "_game_over"});
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pixel(logic [NR-1:0] rocks, logic b, logic s);
    rock_pixel   = rocks;
    bullet_pixel = b;
    ship_pixel   = s;
    tick();
    rock_pixel   = '0;
    bullet_pixel = 1'b0;
    ship_pixel   = 1'b0;
  endtask

  // Drives frame_end in cycle T and returns at the falling edge of T+1.
  task automatic frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic run_frame(logic [NR-1:0] rocks, logic b, logic s);
    pixel(rocks, b, s);
    frame();
    tick(11);
  endtask

  initial begin
    tick(2);
    push_reset_values("reset");
    check();
    resetn = 1'b1;
    tick();

    // Single bullet hit on rock 3
    pixel(10'h008, 1'b1, 1'b0);
    frame();
    push_exp(S_RR, 16'h0008, "r3_rock_reset_t1");
    push_exp(S_BH, 16'h0001, "r3_bullet_hit_t1");
    push_exp(S_SH, 16'h0000, "r3_ship_hit_t1");
    check();
    tick();
    push_exp(S_RR, 16'h0000, "r3_rock_reset_t2");
    push_exp(S_BH, 16'h0000, "r3_bullet_hit_t2");
    check();
    tick(10);
    hits = 1;
    push_exp(S_SC, to_bcd(hits), "r3_score_t12");
    check();

    // Preset 0990, then rocks 0, 5, 9 carry into the thousands digit
    for (int f = 0; f < 9; f++) run_frame('1, 1'b1, 1'b0);
    run_frame(10'h0FF, 1'b1, 1'b0);
    hits += 98;
    push_exp(S_SC, 16'h0990, "preset_0990");
    check();
    pixel(10'h221, 1'b1, 1'b0);
    frame();
    push_exp(S_RR, 16'h0221, "multi_rock_reset");
    push_exp(S_BH, 16'h0001, "multi_bullet_hit");
    check();
    tick(11);
    hits += 3;
    push_exp(S_SC, 16'h1020, "multi_score_1020");
    check();

    // Fill to saturation
    for (int f = 0; f < 89; f++) run_frame('1, 1'b1, 1'b0);
    run_frame(10'h07F, 1'b1, 1'b0);
    hits += 897;
    push_exp(S_SC, to_bcd(hits), "preset_9990");
    check();

    // Hit at 9990; overlap at T+3 and ignored frame_end at T+5 carry over
    pixel(10'h004, 1'b1, 1'b0);
    frame();
    push_exp(S_RR, 16'h0004, "sat_rock_reset");
    push_exp(S_BH, 16'h0001, "sat_bullet_hit");
    check();
    tick();
    tick();
    pixel(10'h010, 1'b1, 1'b0);
    tick();
    frame();
    push_exp(S_RR, 16'h0000, "ignored_fe_rock_reset");
    push_exp(S_BH, 16'h0000, "ignored_fe_bullet_hit");
    check();
    tick(6);
    hits += 1;
    push_exp(S_SC, 16'h9990, "sat_score_held");
    check();
    frame();
    push_exp(S_RR, 16'h0010, "carried_rock_reset");
    push_exp(S_BH, 16'h0001, "carried_bullet_hit");
    check();
    tick(11);
    push_exp(S_SC, 16'h9990, "carried_score_held");
    check();

    // Asynchronous reset in the middle of SCORE
    pixel(10'h040, 1'b1, 1'b0);
    frame();
    tick(3);
    resetn = 1'b0;
    #1;
    push_reset_values("mid_score_reset");
    check();
    tick();
    resetn = 1'b1;
    tick();
    hits = 0;

    // Bullet and ship on the same rock: one retire, one score, one ship hit
    pixel(10'h002, 1'b1, 1'b1);
    frame();
    push_exp(S_RR, 16'h0002, "both_rock_reset");
    push_exp(S_BH, 16'h0001, "both_bullet_hit");
    push_exp(S_SH, 16'h0001, "both_ship_hit");
    push_exp(S_LV, 16'h0002, "both_lives");
    check();
    tick();
    push_exp(S_SH, 16'h0000, "both_ship_hit_t2");
    check();
    tick(10);
    hits = 1;
    push_exp(S_SC, to_bcd(hits), "both_score");
    check();

    // Invulnerable frames after the hit
    pixel(10'h002, 1'b0, 1'b1);
    frame();
    push_exp(S_RR, 16'h0002, "invuln_rock_reset");
    push_exp(S_SH, 16'h0000, "invuln_ship_hit");
    push_exp(S_LV, 16'h0002, "invuln_lives");
    check();
    tick(11);
    for (int f = 0; f < 117; f++) run_frame('0, 1'b0, 1'b0);
    pixel(10'h080, 1'b0, 1'b1);
    frame();
    push_exp(S_SH, 16'h0000, "invuln_f119_ship_hit");
    push_exp(S_LV, 16'h0002, "invuln_f119_lives");
    check();
    tick(11);
    run_frame('0, 1'b0, 1'b0);
    pixel(10'h080, 1'b0, 1'b1);
    frame();
    push_exp(S_SH, 16'h0001, "second_ship_hit");
    push_exp(S_LV, 16'h0001, "second_lives");
    push_exp(S_GO, 16'h0000, "second_game_over");
    check();
    tick(11);

    // Third hit ends the game
    for (int f = 0; f < 120; f++) run_frame('0, 1'b0, 1'b0);
    pixel(10'h200, 1'b0, 1'b1);
    frame();
    push_exp(S_SH, 16'h0001, "third_ship_hit");
    push_exp(S_LV, 16'h0000, "third_lives");
    push_exp(S_GO, 16'h0001, "third_game_over");
    check();
    tick(11);

    // After game over: rocks still retire, nothing else moves
    pixel(10'h100, 1'b1, 1'b1);
    frame();
    push_exp(S_RR, 16'h0100, "go_rock_reset");
    push_exp(S_BH, 16'h0001, "go_bullet_hit");
    push_exp(S_SH, 16'h0000, "go_ship_hit");
    push_exp(S_LV, 16'h0000, "go_lives");
    push_exp(S_GO, 16'h0001, "go_game_over");
    check();
    tick(11);
    push_exp(S_SC, to_bcd(hits), "go_score_frozen");
    check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
